// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions used by the device transmitter and host receiver.
// Holds the frame layout, FSM state encoding, break code and parity helper.
package ps2_pkg;

    localparam int unsigned FRAME_BITS = 11;
    localparam logic [7:0]  BREAK_CODE = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_HOLD  = 2'd2,
        ST_GAP   = 2'd3
    } ps2_state_e;

    // On-wire frame, LSB (start) first
    typedef struct packed {
        logic       stop;
        logic       parity;
        logic [7:0] data;
        logic       start;
    } ps2_frame_t;

    // Odd parity: set when the data byte has an even number of ones
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Synchronous byte FIFO feeding the PS/2 transmitter.
// Ports: clk/clrn, wr_en/wr_data (write dropped when full), rd_en/rd_data
// (show-ahead read), registered full/empty flags and occupancy count.
module ps2_tx_fifo #(
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned CW    = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_nx;
    logic          do_wr;
    logic          do_rd;

    // full is the registered flag, so a write while full is dropped even on a pop cycle
    assign do_wr    = wr_en & ~full;
    assign do_rd    = rd_en & ~empty;
    assign count_nx = count + CW'(do_wr) - CW'(do_rd);
    assign rd_data  = mem[rd_ptr];

    // Pointers, occupancy and flags
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count_nx;
            full  <= (count_nx == CW'(DEPTH));
            empty <= (count_nx == '0);
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter (keyboard emulator).
// Buffers bytes from wr_en/wr_data and sends each as an 11-bit frame on
// ps2_clk/ps2_data. inhibit holds off transmission and aborts a frame in
// flight, which is then retransmitted after the inter-frame gap.
// Outputs: full/overflow (FIFO status), busy (not idle), ps2_clk/ps2_data.
module ps2_device_tx
    import ps2_pkg::*;
#(
    parameter int unsigned HALF = 16,
    parameter int unsigned GAP  = 64,
    parameter int unsigned AW   = 3
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    input  logic       inhibit,
    output logic       full,
    output logic       busy,
    output logic       overflow,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int unsigned PW    = $clog2(2 * HALF);
    localparam int unsigned GW    = $clog2(GAP + 1);
    localparam int unsigned BW    = 4;
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned DEPTH = 2 ** AW;

    ps2_state_e           state, state_nx;
    ps2_frame_t           frame_q;
    logic [FRAME_BITS-1:0] frame_bits;
    logic [PW-1:0]        phase;
    logic [BW-1:0]        bit_cnt;
    logic [GW-1:0]        gap_cnt;
    logic                 retry;

    logic                 fifo_empty;
    logic [7:0]           fifo_rd_data;
    logic [AW:0]          fifo_count;

    logic                 abort_c;
    logic                 last_c;
    logic                 gap_done_c;
    logic                 pop_c;
    logic                 clk_nx;
    logic                 data_nx;

    assign frame_bits = frame_q;

    ps2_tx_fifo #(.AW(AW)) u_fifo (
        .clk     (clk),
        .clrn    (clrn),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop_c),
        .rd_data (fifo_rd_data),
        .full    (full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Occupancy sanity: never above the FIFO depth
    always_comb begin
        assert (fifo_count <= CW'(DEPTH));
    end

    // Once the falling edge of the stop bit has been issued the frame counts as delivered
    assign abort_c    = inhibit && !((bit_cnt == BW'(FRAME_BITS - 1)) && (phase >= PW'(HALF)));
    assign last_c     = (bit_cnt == BW'(FRAME_BITS - 1)) && (phase == PW'(2 * HALF - 1));
    assign gap_done_c = !inhibit && (gap_cnt == GW'(GAP - 1));

    // State register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (!fifo_empty && !inhibit) state_nx = ST_FRAME;
            ST_FRAME: if (abort_c)                 state_nx = ST_HOLD;
                      else if (last_c)             state_nx = ST_GAP;
            ST_HOLD:  if (!inhibit)                state_nx = ST_GAP;
            ST_GAP:   if (gap_done_c)              state_nx = retry ? ST_FRAME : ST_IDLE;
            default:                               state_nx = ST_IDLE;
        endcase
    end

    // Output decode: next values of the registered line drivers and the FIFO pop
    always_comb begin
        clk_nx  = 1'b1;
        data_nx = 1'b1;
        pop_c   = 1'b0;
        if (state == ST_FRAME && !abort_c) begin
            clk_nx  = (phase < PW'(HALF));
            data_nx = (phase == '0) ? frame_bits[bit_cnt] : ps2_data;
        end
        if (state == ST_IDLE && state_nx == ST_FRAME) pop_c = 1'b1;
    end

    // Counters, frame register and registered outputs
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            frame_q  <= '1;
            phase    <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            retry    <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
        end else begin
            if (pop_c) begin
                frame_q <= '{stop: 1'b1, parity: odd_parity(fifo_rd_data),
                             data: fifo_rd_data, start: 1'b0};
            end

            if (state != ST_FRAME && state_nx == ST_FRAME) begin
                phase   <= '0;
                bit_cnt <= '0;
            end else if (state == ST_FRAME) begin
                if (phase == PW'(2 * HALF - 1)) begin
                    phase   <= '0;
                    bit_cnt <= bit_cnt + BW'(1);
                end else begin
                    phase <= phase + PW'(1);
                end
            end

            // Any inhibit during the gap restarts the count
            if (state == ST_GAP && !inhibit) gap_cnt <= gap_cnt + GW'(1);
            else                             gap_cnt <= '0;

            if (state == ST_HOLD && state_nx == ST_GAP)     retry <= 1'b1;
            else if (state == ST_GAP && state_nx != ST_GAP) retry <= 1'b0;

            busy     <= (state_nx != ST_IDLE);
            overflow <= overflow | (wr_en & full);
            ps2_clk  <= clk_nx;
            ps2_data <= data_nx;
        end
    end

endmodule
